// File: rtl/packet_arbiter_rr.sv
// packet_arbiter_rr: round-robin, packet-locked arbiter for one router output.
// An idle output grants the first requesting input at or after the pointer.
// The owner then holds the output until its last flit transfers. The pointer
// then moves one past the released owner so that every input gets a turn.
module packet_arbiter_rr #(
  parameter int unsigned CHANNEL_NUMBER = 5,
  parameter int unsigned ID_WIDTH       = $clog2(CHANNEL_NUMBER)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNEL_NUMBER-1:0] req_i,
  input  logic [CHANNEL_NUMBER-1:0] last_i,
  input  logic                      out_ready_i,
  output logic [CHANNEL_NUMBER-1:0] grant_o,
  output logic [ID_WIDTH-1:0]       grant_id_o,
  output logic                      busy_o,
  output logic                      xfer_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(CHANNEL_NUMBER - 1);

  logic [0:0]                state_q,    state_d;
  logic [ID_WIDTH-1:0]       ptr_q,      ptr_d;
  logic [CHANNEL_NUMBER-1:0] grant_q,    grant_d;
  logic [ID_WIDTH-1:0]       grant_id_q, grant_id_d;
  logic                      busy_q,     busy_d;

  logic                      any_req;
  logic [ID_WIDTH-1:0]       win_id;
  logic [CHANNEL_NUMBER-1:0] win_onehot;
  logic                      xfer;
  logic                      owner_last;
  logic [ID_WIDTH-1:0]       ptr_after_owner;

  // First set request bit scanning upward from ptr, wrapping past the top input.
  function automatic logic [ID_WIDTH-1:0] rr_pick(
    input logic [CHANNEL_NUMBER-1:0] req,
    input logic [ID_WIDTH-1:0]       ptr
  );
    logic                found;
    logic [ID_WIDTH-1:0] win;
    int unsigned         idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
      idx = (32'(ptr) + k) % CHANNEL_NUMBER;
      if (!found && req[ID_WIDTH'(idx)]) begin
        found = 1'b1;
        win   = ID_WIDTH'(idx);
      end
    end
    return win;
  endfunction

  // Arbitration candidate for the next grant, evaluated every cycle.
  always_comb begin
    any_req             = |req_i;
    win_id              = rr_pick(req_i, ptr_q);
    win_onehot          = '0;
    win_onehot[win_id]  = 1'b1;
  end

  // Transfer handshake and release qualifiers for the current owner.
  always_comb begin
    xfer            = (|(grant_q & req_i)) & out_ready_i;
    owner_last      = last_i[grant_id_q];
    ptr_after_owner = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_WIDTH'(1);
  end

  // Next-state and next-output logic: grant on request, release on last flit.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d    = ST_LOCKED;
          grant_d    = win_onehot;
          grant_id_d = win_id;
          busy_d     = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (xfer && owner_last) begin
          state_d    = ST_IDLE;
          ptr_d      = ptr_after_owner;
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any lock and rewinds the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = busy_q;
  assign xfer_o     = xfer;

endmodule

// File: tb/tb_packet_arbiter_rr.sv
// tb_packet_arbiter_rr: directed scenarios plus random traffic, checked
// every cycle against a small owner/pointer model of the arbiter.
module tb_packet_arbiter_rr;

  localparam int N = 5;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic         rdy;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic         busy;
  logic         xfer;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = none) and round-robin pointer.
  int m_owner = -1;
  int m_ptr   = 0;

  packet_arbiter_rr #(.CHANNEL_NUMBER(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .last_i     (last),
    .out_ready_i(rdy),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .xfer_o     (xfer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, advance both.
  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] ls,
                      input logic rd, input logic rs);
    logic [N-1:0] eg;
    logic         ex;
    req  = rq;
    last = ls;
    rdy  = rd;
    rst  = rs;
    #1;
    eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
    ex = (m_owner >= 0) && rq[m_owner] && rd;
    check("model_grant",    32'(grant),    32'(eg));
    check("model_grant_id", 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("model_busy",     32'(busy),     32'(m_owner >= 0));
    check("model_xfer",     32'(xfer),     32'(ex));
    @(posedge clk);
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
    end else if (ex && ls[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
    @(negedge clk);
  endtask

  initial begin
    req  = '0;
    last = '0;
    rdy  = 1'b0;
    rst  = 1'b1;
    @(negedge clk);

    // Reset state
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    check("rst_grant",    32'(grant),    32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);

    // First grant after reset
    step(5'b10100, 5'b00000, 1'b0, 1'b0);
    check("first_grant",    32'(grant),    32'b00100);
    check("first_grant_id", 32'(grant_id), 32'd2);
    check("first_busy",     32'(busy),     32'd1);

    // Three-flit packet from input 2, then pointer sits at 3
    step(5'b00100, 5'b00000, 1'b1, 1'b0);
    check("pkt3_hold1", 32'(grant), 32'b00100);
    step(5'b00100, 5'b00000, 1'b1, 1'b0);
    check("pkt3_hold2", 32'(grant), 32'b00100);
    step(5'b00100, 5'b00100, 1'b1, 1'b0);
    check("pkt3_release", 32'(grant), 32'd0);
    check("pkt3_idle",    32'(busy),  32'd0);
    step(5'b10011, 5'b00000, 1'b1, 1'b0);
    check("ptr3_grant4", 32'(grant), 32'b10000);

    // Owner 4 releases, pointer wraps to 0
    step(5'b10001, 5'b10000, 1'b1, 1'b0);
    check("wrap_release", 32'(grant), 32'd0);
    step(5'b10001, 5'b00000, 1'b1, 1'b0);
    check("wrap_grant0", 32'(grant), 32'b00001);
    step(5'b00001, 5'b00001, 1'b1, 1'b0);

    // All inputs, single-flit packets: 0,1,2,3,4,0 with idle bubbles
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    for (int g = 0; g < 6; g++) begin
      step(5'b11111, 5'b11111, 1'b1, 1'b0);
      check("rr_grant", 32'(grant), 32'(1) << (g % N));
      step(5'b11111, 5'b11111, 1'b1, 1'b0);
      check("rr_bubble", 32'(grant), 32'd0);
    end

    // Owner 1 stalled by downstream while input 3 requests
    step(5'b00010, 5'b00000, 1'b0, 1'b0);
    check("stall_grant", 32'(grant), 32'b00010);
    for (int c = 0; c < 4; c++) begin
      step(5'b01010, 5'b11111, 1'b0, 1'b0);
      check("stall_hold", 32'(grant), 32'b00010);
      check("stall_xfer", 32'(xfer),  32'd0);
    end
    // Owner bubble does not release the lock
    step(5'b01000, 5'b00010, 1'b1, 1'b0);
    check("bubble_hold", 32'(grant), 32'b00010);
    step(5'b00010, 5'b00010, 1'b1, 1'b0);
    check("stall_release", 32'(grant), 32'd0);

    // Reset mid-packet with owner 3
    step(5'b01000, 5'b00000, 1'b1, 1'b0);
    check("mid_grant3", 32'(grant), 32'b01000);
    step(5'b01000, 5'b00000, 1'b1, 1'b0);
    step(5'b01000, 5'b01000, 1'b1, 1'b1);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy",  32'(busy),  32'd0);
    step(5'b01001, 5'b00000, 1'b1, 1'b0);
    check("mid_rst_grant0", 32'(grant),    32'b00001);
    check("mid_rst_id0",    32'(grant_id), 32'd0);

    // Non-owner last bits are ignored
    step(5'b00011, 5'b00010, 1'b1, 1'b0);
    check("nonowner_last", 32'(grant), 32'b00001);
    step(5'b00001, 5'b00001, 1'b1, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(N'($urandom), N'($urandom), 1'($urandom_range(3) != 0),
           1'($urandom_range(40) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/packet_arbiter_rr.md
PACKET_ARBITER_RR -- requirements
Module: packet_arbiter_rr

Interface
REQ-001 SHALL have parameter CHANNEL_NUMBER, default 5, number of router input channels competing for this output.
REQ-002 SHALL have parameter ID_WIDTH, default $clog2(CHANNEL_NUMBER), width of grant_id_o.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  CHANNEL_NUMBER  bit i = input i holds a valid flit routed to this output (route-select bit ANDed with valid).
REQ-006 SHALL have port last_i  input  CHANNEL_NUMBER  bit i = flit currently offered by input i is the last of its packet.
REQ-007 SHALL have port out_ready_i  input  1  downstream accepts a flit this cycle.
REQ-008 SHALL have port grant_o  output  CHANNEL_NUMBER  one-hot or zero; input currently owning this output.
REQ-009 SHALL have port grant_id_o  output  ID_WIDTH  binary index of granted input; 0 when no grant.
REQ-010 SHALL have port busy_o  output  1  high while in LOCKED.
REQ-011 SHALL have port xfer_o  output  1  combinational; high when a flit transfers this cycle.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and LOCKED (one owner).
REQ-013 SHALL keep a registered round-robin pointer ptr (ID_WIDTH bits), range 0..CHANNEL_NUMBER-1.
REQ-014 In IDLE with req_i != 0, SHALL pick the winner as the first set req_i bit searching ptr, ptr+1, ... modulo CHANNEL_NUMBER, register grant_o/grant_id_o to it and enter LOCKED at the next edge; arbitration latency is 1 cycle.
REQ-015 In IDLE with req_i == 0, SHALL stay in IDLE with grant_o = 0.
REQ-016 SHALL assert xfer_o = |(grant_o & req_i) & out_ready_i; combinational, no registered delay.
REQ-017 In LOCKED, SHALL hold grant_o unchanged regardless of other req_i bits or deassertion of the owner's req_i bit (owner bubbles do not release the lock).
REQ-018 In LOCKED, when xfer_o is high and last_i[grant_id_o] is high, SHALL return to IDLE, clear grant_o and grant_id_o, and set ptr = (grant_id_o + 1) mod CHANNEL_NUMBER at that edge.
REQ-019 In LOCKED, when xfer_o is high and last_i of the owner is low, SHALL remain LOCKED; there is no limit on packet length.
REQ-020 A single-flit packet (last_i high on first transfer) SHALL occupy exactly 2 cycles: 1 arbitration cycle and 1 transfer cycle.
REQ-021 After a release, SHALL spend at least one cycle in IDLE before the next grant; back-to-back packets have a 1-cycle bubble.
REQ-022 ptr wrap-around SHALL yield 0 after CHANNEL_NUMBER-1 for non-power-of-two CHANNEL_NUMBER.
REQ-023 SHALL keep grant_o one-hot or zero in every cycle, with grant_id_o consistent with it.
REQ-024 busy_o SHALL equal (state == LOCKED).
REQ-025 last_i bits of non-owner inputs SHALL be ignored.

Reset
REQ-026 With rst_i high at a rising edge, SHALL set state = IDLE, ptr = 0, grant_o = 0, grant_id_o = 0 and busy_o = 0, overriding any transfer in that cycle.
REQ-027 Reset asserted mid-packet SHALL drop the lock; the first arbitration after reset SHALL start from ptr = 0.

Verification
REQ-028 Bench SHALL cover: after reset, req_i=5'b10100 -> next cycle grant_o=5'b00100, grant_id_o=2, busy_o=1.
REQ-029 Bench SHALL cover: owner 2, 3-flit packet, out_ready_i=1, last_i[2] on the 3rd transfer -> grant held 3 cycles, then grant_o=0, ptr=3, then input 4 granted.
REQ-030 Bench SHALL cover: all 5 inputs requesting continuously with single-flit packets -> grant order 0,1,2,3,4,0, each grant separated by 1 idle cycle.
REQ-031 Bench SHALL cover: owner 1 locked, out_ready_i=0 for 4 cycles, req_i[3] asserted meanwhile -> grant_o stays 5'b00010, xfer_o=0 throughout.
REQ-032 Bench SHALL cover: owner 4 releases -> ptr wraps to 0; req_i=5'b10001 -> input 0 granted.
REQ-033 Bench SHALL cover: rst_i pulsed mid-packet with owner 3 -> next cycle grant_o=0, busy_o=0; req_i=5'b01001 -> input 0 granted.
